// File: rtl/array_alloc_pkg.sv
// Shared types for the array-handle allocator: FSM states, op encoding and handle type.
package array_alloc_pkg;
  localparam int MEM_W = 12;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic OP_ALLOC = 1'b0;
  localparam logic OP_FREE  = 1'b1;

  typedef logic [MEM_W-1:0] handle_t;
endpackage

// File: rtl/array_allocator_rr_arbiter2.sv
// Two-way round-robin grant; on a tie the port that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req_valid,
  output logic [1:0] grant
);
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last_grant <= 1'b1;
    else if (|grant)
      last_grant <= grant[1];
  end
endmodule

// File: rtl/array_allocator.sv
// Array-handle allocator: bitmap, freed-handle stack and size table, serving two requesters
// one operation at a time through an IDLE -> EXEC -> RESP sequence.
module array_allocator
  import array_alloc_pkg::*;
#(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic [1:0]                      req_free,
  input  logic [2*MemoryElementWidth-1:0] req_array,
  output logic                            rsp_valid,
  output logic                            rsp_port,
  output logic [MemoryElementWidth-1:0]   rsp_array,
  output logic                            rsp_error,
  input  logic                            size_we,
  input  logic [MemoryElementWidth-1:0]   size_array,
  input  logic [MemoryElementWidth-1:0]   size_index,
  input  logic [MemoryElementWidth-1:0]   size_rd_array,
  output logic [MemoryElementWidth-1:0]   size_rd_value,
  output logic [MemoryElementWidth-1:0]   allocs,
  output logic [MemoryElementWidth-1:0]   allocs_max
);
  localparam int W   = MemoryElementWidth;
  localparam int IW  = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int SPW = $clog2(NArrays + 1);
  localparam logic [W-1:0] N_H = W'(NArrays);

  state_t             state;
  logic               cap_port;
  logic               cap_op;
  logic [W-1:0]       cap_array;
  logic [NArrays-1:0] bitmap;
  logic [W-1:0]       stack [NArrays];
  logic [SPW-1:0]     sp;
  logic [W-1:0]       next_fresh;
  logic [W-1:0]       sizes [NArrays];
  logic [1:0]         grant;

  logic [SPW-1:0] sp_m1;
  logic           pop, alloc_ok, free_ok, free_go, sz_hit;
  logic [W-1:0]   alloc_h, allocs_inc, sz_idx1;

  rr_arbiter2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .enable    (state == IDLE && !reset),
    .req_valid (req_valid),
    .grant     (grant)
  );

  assign req_ready     = grant;
  assign size_rd_value = (size_rd_array < N_H) ? sizes[size_rd_array[IW-1:0]] : '0;

  always_comb begin
    sp_m1      = sp - SPW'(1);
    pop        = (sp != '0);
    alloc_ok   = pop || (next_fresh < N_H);
    alloc_h    = pop ? stack[sp_m1[IW-1:0]] : next_fresh;
    allocs_inc = allocs + W'(1);
    free_ok    = (cap_array < N_H) && bitmap[cap_array[IW-1:0]];
    free_go    = (state == EXEC) && (cap_op == OP_FREE) && free_ok;
    sz_idx1    = size_index + W'(1);
    // A length write racing a free of the same handle is dropped; idx+1 wrapping to 0 never grows
    sz_hit     = size_we && (size_array < N_H) && bitmap[size_array[IW-1:0]]
                 && (sizes[size_array[IW-1:0]] < sz_idx1)
                 && !(free_go && (cap_array == size_array));
  end

  // Accept stage: capture the granted request
  always_ff @(posedge clock) begin
    if (state == IDLE && |grant) begin
      cap_port  <= grant[1];
      cap_op    <= grant[1] ? req_free[1] : req_free[0];
      cap_array <= grant[1] ? req_array[2*W-1:W] : req_array[W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (free_go)
      stack[sp[IW-1:0]] <= cap_array;
  end

  // Execute and respond stages
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_port   <= 1'b0;
      rsp_array  <= '0;
      rsp_error  <= 1'b0;
      allocs     <= '0;
      allocs_max <= '0;
      bitmap     <= '0;
      sp         <= '0;
      next_fresh <= '0;
      for (int i = 0; i < NArrays; i++) sizes[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (sz_hit)
        sizes[size_array[IW-1:0]] <= sz_idx1;
      case (state)
        IDLE: if (|grant) state <= EXEC;
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_port  <= cap_port;
          rsp_error <= 1'b0;
          if (cap_op == OP_ALLOC) begin
            rsp_array <= alloc_h;
            if (alloc_ok) begin
              bitmap[alloc_h[IW-1:0]] <= 1'b1;
              sizes[alloc_h[IW-1:0]]  <= '0;
              allocs                  <= allocs_inc;
              if (allocs_inc > allocs_max) allocs_max <= allocs_inc;
              if (pop) sp <= sp_m1;
              else     next_fresh <= next_fresh + W'(1);
            end else begin
              rsp_error <= 1'b1;
            end
          end else begin
            rsp_array <= cap_array;
            if (free_ok) begin
              bitmap[cap_array[IW-1:0]] <= 1'b0;
              sp                        <= sp + SPW'(1);
              allocs                    <= allocs - W'(1);
            end else begin
              rsp_error <= 1'b1;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
